// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit constants and countdown state encoding
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cd_state_t;
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_countdown_if.sv
// bcd_countdown_if: control/data bundle between a driver and the BCD countdown
interface bcd_countdown_if #(parameter int DIGITS = 2);
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_value;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_tick;
  logic [4*DIGITS-1:0]   o_count;
  logic                  o_running;
  logic                  o_done;
  logic                  o_done_pulse;
  modport master (output i_load, i_load_value, i_start, i_stop, i_tick,
                  input  o_count, o_running, o_done, o_done_pulse);
  modport slave  (input  i_load, i_load_value, i_start, i_stop, i_tick,
                  output o_count, o_running, o_done, o_done_pulse);
endinterface

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit decrement stage; wraps 0->9 and passes the borrow upward
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_borrow,
  output bcd_digit_t o_digit,
  output logic       o_borrow
);
  assign o_digit  = !i_borrow ? i_digit : (i_digit == BCD_ZERO) ? BCD_MAX : i_digit - 4'd1;
  assign o_borrow = i_borrow & (i_digit == BCD_ZERO);
endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: loadable multi-digit BCD down-counter with run/stop and terminal detect.
// Define COUNTDOWN_AUTORELOAD_EN to reload the preset instead of stopping at zero.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input logic            clk,
  input logic            rst,
  bcd_countdown_if.slave bus
);
  localparam int W = 4 * DIGITS;
  cd_state_t    r_state, w_state;
  logic [W-1:0] r_count, w_count, r_reload, w_reload, w_dec, w_load_san;
  logic         r_pulse, w_pulse;
  logic [DIGITS:0] w_borrow;
  logic         w_zero, w_last;
  assign w_borrow[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_dec u_dec (
      .i_digit (r_count[4*i +: 4]),
      .i_borrow(w_borrow[i]),
      .o_digit (w_dec[4*i +: 4]),
      .o_borrow(w_borrow[i+1])
    );
    assign w_load_san[4*i +: 4] = bcd_clamp(bus.i_load_value[4*i +: 4]);
  end
  // a borrow out of the top digit means every digit was zero
  assign w_zero = w_borrow[DIGITS];
  assign w_last = (w_dec == '0) && !w_zero;
  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_reload = r_reload;
    w_pulse  = 1'b0;
    if (bus.i_load) begin
      w_count  = w_load_san;
      w_reload = w_load_san;
      w_state  = IDLE;
    end else if (r_state == IDLE && !bus.i_stop && bus.i_start) begin
      w_state = w_zero ? DONE : RUN;
      w_pulse = w_zero;
    end else if (r_state == RUN && bus.i_stop) begin
      w_state = IDLE;
    end else if (r_state == RUN && bus.i_tick && !w_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      w_count = w_last ? r_reload : w_dec;
`else
      w_count = w_dec;
      w_state = w_last ? DONE : RUN;
`endif
      w_pulse = w_last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_reload <= w_reload;
      r_pulse  <= w_pulse;
    end
  end
  assign bus.o_count      = r_count;
  assign bus.o_running    = (r_state == RUN);
  assign bus.o_done       = (r_state == DONE);
  assign bus.o_done_pulse = r_pulse;
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed self-checking bench for bcd_countdown (DIGITS=2)
module tb_bcd_countdown;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bcd_countdown_if #(.DIGITS(2)) bus ();
  bcd_countdown #(.DIGITS(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [7:0] v);
    bus.i_load = 1'b1; bus.i_load_value = v; cyc(); bus.i_load = 1'b0;
  endtask
  task automatic start();
    bus.i_start = 1'b1; cyc(); bus.i_start = 1'b0;
  endtask
  task automatic stop();
    bus.i_stop = 1'b1; cyc(); bus.i_stop = 1'b0;
  endtask
  task automatic tick();
    bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0;
  endtask
  logic [7:0] seq10 [10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  initial begin
    bus.i_load = 1'b0; bus.i_load_value = '0; bus.i_start = 1'b0;
    bus.i_stop = 1'b0; bus.i_tick = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_count", {24'd0, bus.o_count}, 32'h00);
    chk("rst_running", {31'd0, bus.o_running}, 0);
    chk("rst_done", {31'd0, bus.o_done}, 0);
    chk("rst_pulse", {31'd0, bus.o_done_pulse}, 0);
    start();
    chk("start_zero_after_rst_done", {31'd0, bus.o_done}, 1);
    load(8'h10);
    chk("load10_count", {24'd0, bus.o_count}, 32'h10);
    chk("load10_idle", {31'd0, bus.o_running}, 0);
    chk("load10_done_clr", {31'd0, bus.o_done}, 0);
    tick();
    chk("idle_tick_ignored", {24'd0, bus.o_count}, 32'h10);
    start();
    chk("start_running", {31'd0, bus.o_running}, 1);
`ifndef COUNTDOWN_AUTORELOAD_EN
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("seq10_t%0d", k + 1), {24'd0, bus.o_count}, {24'd0, seq10[k]});
      chk($sformatf("seq10_pulse%0d", k + 1), {31'd0, bus.o_done_pulse}, (k == 9) ? 32'd1 : 32'd0);
    end
    chk("seq10_done", {31'd0, bus.o_done}, 1);
    chk("seq10_not_running", {31'd0, bus.o_running}, 0);
    cyc();
    chk("seq10_pulse_one_cycle", {31'd0, bus.o_done_pulse}, 0);
    tick(); tick();
    bus.i_start = 1'b1; bus.i_stop = 1'b1; cyc(); bus.i_start = 1'b0; bus.i_stop = 1'b0;
    chk("done_hold_count", {24'd0, bus.o_count}, 32'h00);
    chk("done_hold_state", {31'd0, bus.o_done}, 1);
`else
    for (int k = 0; k < 10; k++) tick();
    chk("ar_seq10_wrap", {24'd0, bus.o_count}, 32'h10);
    chk("ar_seq10_running", {31'd0, bus.o_running}, 1);
    chk("ar_seq10_pulse", {31'd0, bus.o_done_pulse}, 1);
`endif
    load(8'h20); start(); tick();
    chk("borrow_20_19", {24'd0, bus.o_count}, 32'h19);
    load(8'h3F);
    chk("clamp_3F_39", {24'd0, bus.o_count}, 32'h39);
    load(8'hA7);
    chk("clamp_A7_97", {24'd0, bus.o_count}, 32'h97);
    load(8'h05); start(); tick(); tick(); stop();
    tick(); tick(); tick();
    chk("stop_count", {24'd0, bus.o_count}, 32'h03);
    chk("stop_running", {31'd0, bus.o_running}, 0);
    start(); tick();
    chk("resume_count", {24'd0, bus.o_count}, 32'h02);
    bus.i_start = 1'b1; bus.i_tick = 1'b1; cyc(); bus.i_start = 1'b0; bus.i_tick = 1'b0;
    chk("start_in_run_tick", {24'd0, bus.o_count}, 32'h01);
    bus.i_load = 1'b1; bus.i_load_value = 8'h47; bus.i_tick = 1'b1; cyc();
    bus.i_load = 1'b0; bus.i_tick = 1'b0;
    chk("load_tick_count", {24'd0, bus.o_count}, 32'h47);
    chk("load_tick_idle", {31'd0, bus.o_running}, 0);
    chk("load_tick_pulse", {31'd0, bus.o_done_pulse}, 0);
    load(8'h00); start();
    chk("zero_start_done", {31'd0, bus.o_done}, 1);
    chk("zero_start_pulse", {31'd0, bus.o_done_pulse}, 1);
    cyc();
    chk("zero_start_pulse_clr", {31'd0, bus.o_done_pulse}, 0);
    load(8'h05); start(); tick();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrun_rst_count", {24'd0, bus.o_count}, 32'h00);
    chk("midrun_rst_running", {31'd0, bus.o_running}, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    load(8'h02); start();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("ar_count%0d", k + 1), {24'd0, bus.o_count}, (k % 2 == 0) ? 32'h01 : 32'h02);
      chk($sformatf("ar_pulse%0d", k + 1), {31'd0, bus.o_done_pulse}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("ar_running%0d", k + 1), {31'd0, bus.o_running}, 1);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
